// File: rtl/led_pkg.sv
// Shared types and helpers for the multiplexed LED driver.
package led_pkg;

  localparam int LED_DWELL_DEFAULT = 25_000_000;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } led_state_e;

  // Applies pin polarity; callers cast the result down to the bus width (max 32).
  function automatic logic [31:0] drive(input logic [31:0] val, input bit active_low);
    return active_low ? ~val : val;
  endfunction

endpackage

// File: rtl/led_blink.sv
// Frame counter and blink phase; advances once per frame while blinking is enabled.
module led_blink #(
  parameter int BLINK_FRAMES = 8
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic frame_start,
  input  logic blink_en,
  output logic blink_off
);

  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(BLINK_FRAMES - 1);

  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           phase_off_q, phase_off_d;

  always_comb begin
    fcnt_d      = fcnt_q;
    phase_off_d = phase_off_q;
    if (!blink_en) begin
      fcnt_d      = '0;
      phase_off_d = 1'b0;
    end else if (frame_start) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d      = '0;
        phase_off_d = ~phase_off_q;
      end else begin
        fcnt_d = fcnt_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q      <= '0;
      phase_off_q <= 1'b0;
    end else begin
      fcnt_q      <= fcnt_d;
      phase_off_q <= phase_off_d;
    end
  end

  assign blink_off = phase_off_q & blink_en;

endmodule

// File: rtl/led_scan.sv
// Time-multiplexed LED scanner with frame-synchronous data update, blanking and blink.
//   state | meaning
//   LOAD  | one cycle per frame: shadow update, frame_start, outputs inactive
//   SHOW  | group grp_q driven for DWELL cycles
//   GAP   | BLANK dead cycles after each group, outputs inactive
module led_scan
  import led_pkg::*;
#(
  parameter int GROUPS       = 2,
  parameter int GW           = 4,
  parameter int DWELL        = LED_DWELL_DEFAULT,
  parameter int BLANK        = 0,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int BLINK_FRAMES = 8
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic [GROUPS*GW-1:0] data,
  input  logic                 data_vld,
  input  logic                 blink_en,
  output logic [GROUPS-1:0]    sel,
  output logic [GW-1:0]        led,
  output logic                 frame_start
);

  localparam int DW  = GROUPS * GW;
  localparam int CW  = $clog2(DWELL + BLANK + 1);
  localparam int GIW = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  localparam logic [CW-1:0]     DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0]     GAP_LAST   = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [GIW-1:0]    GRP_LAST   = GIW'(GROUPS - 1);
  localparam logic [GROUPS-1:0] SEL_OFF    = GROUPS'(drive(32'd0, ACTIVE_LOW));
  localparam logic [GW-1:0]     LED_OFF    = GW'(drive(32'd0, ACTIVE_LOW));

  led_state_e        state_q, state_d;
  logic [GIW-1:0]    grp_q, grp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     shadow_q, shadow_d;
  logic              pend_q, pend_d;
  logic [DW-1:0]     pend_data_q, pend_data_d;
  logic [GROUPS-1:0] sel_q, sel_d;
  logic [GW-1:0]     led_q, led_d;
  logic              fs_q, fs_d;
  logic              show_entry;
  logic              blink_off;

  always_comb begin
    state_d     = state_q;
    grp_d       = grp_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    sel_d       = SEL_OFF;
    led_d       = LED_OFF;
    show_entry  = 1'b0;

    unique case (state_q)
      LOAD: begin
        if (pend_q) begin
          shadow_d = pend_data_q;
          pend_d   = 1'b0;
        end
        state_d    = SHOW;
        grp_d      = '0;
        cnt_d      = '0;
        show_entry = 1'b1;
      end
      SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (BLANK > 0) begin
            state_d = GAP;
          end else if (grp_q == GRP_LAST) begin
            state_d = LOAD;
          end else begin
            grp_d      = grp_q + GIW'(1);
            show_entry = 1'b1;
          end
        end else begin
          // Hold the pattern chosen at group entry so blink changes only land on boundaries.
          cnt_d = cnt_q + CW'(1);
          sel_d = sel_q;
          led_d = led_q;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (grp_q == GRP_LAST) begin
            state_d = LOAD;
          end else begin
            state_d    = SHOW;
            grp_d      = grp_q + GIW'(1);
            show_entry = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = LOAD;
    endcase

    // A strobe in the LOAD cycle lands in pend_data and waits for the next frame.
    if (data_vld) begin
      pend_d      = 1'b1;
      pend_data_d = data;
    end

    if (show_entry && !blink_off) begin
      sel_d = GROUPS'(drive(32'd1 << grp_d, ACTIVE_LOW));
      led_d = GW'(drive(32'(shadow_d[(GROUPS - 1 - int'(grp_d)) * GW +: GW]), ACTIVE_LOW));
    end
  end

  assign fs_d = (state_d == LOAD);

  led_blink #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .frame_start(fs_d),
    .blink_en   (blink_en),
    .blink_off  (blink_off)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      grp_q       <= '0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      sel_q       <= SEL_OFF;
      led_q       <= LED_OFF;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      sel_q       <= sel_d;
      led_q       <= led_d;
      fs_q        <= fs_d;
    end
  end

  assign sel         = sel_q;
  assign led         = led_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_led_scan.sv
// Directed frame-by-frame checks of led_scan (active-low with gap) plus an active-high no-gap instance.
module tb_led_scan;

  typedef struct {
    bit         fs0;
    bit         blink;
    int         s1k;
    logic [7:0] s1v;
    int         s2k;
    logic [7:0] s2v;
    int         bk;
    logic [7:0] word;
    bit         off0;
    bit         off1;
  } frame_t;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic [7:0] data, data2;
  logic       data_vld, data_vld2, blink_en, blink_en2;
  logic [1:0] sel, sel2;
  logic [3:0] led, led2;
  logic       frame_start, frame_start2;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 0;

  frame_t tbl[12];

  always #5 sys_clk = ~sys_clk;

  led_scan #(
    .GROUPS(2), .GW(4), .DWELL(4), .BLANK(1), .ACTIVE_LOW(1'b1), .BLINK_FRAMES(2)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .data(data), .data_vld(data_vld),
    .blink_en(blink_en), .sel(sel), .led(led), .frame_start(frame_start)
  );

  led_scan #(
    .GROUPS(2), .GW(4), .DWELL(4), .BLANK(0), .ACTIVE_LOW(1'b0), .BLINK_FRAMES(2)
  ) dut2 (
    .sys_clk(sys_clk), .rst_n(rst_n), .data(data2), .data_vld(data_vld2),
    .blink_en(blink_en2), .sel(sel2), .led(led2), .frame_start(frame_start2)
  );

  function automatic frame_t mk(bit fs0, bit blink, int s1k, logic [7:0] s1v, int s2k,
                                logic [7:0] s2v, int bk, logic [7:0] word, bit off0, bit off1);
    frame_t f;
    f.fs0 = fs0; f.blink = blink; f.s1k = s1k; f.s1v = s1v; f.s2k = s2k;
    f.s2v = s2v; f.bk = bk; f.word = word; f.off0 = off0; f.off1 = off1;
    return f;
  endfunction

  task automatic cmp(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: {fs,sel,led} got %b required %b", name, act, exp);
    end
  endtask

  // Checks one 11-cycle frame of dut starting at its LOAD cycle, applying the frame's stimulus.
  task automatic check_frame(input int idx, input frame_t f);
    logic [6:0] e;
    blink_en = f.blink;
    for (int k = 0; k < 11; k++) begin
      e = {1'b0, 2'b11, 4'hF};
      if (k == 0) e[6] = f.fs0;
      if (k >= 1 && k <= 4 && !f.off0) e[5:0] = {2'b10, ~f.word[7:4]};
      if (k >= 6 && k <= 9 && !f.off1) e[5:0] = {2'b01, ~f.word[3:0]};
      cmp($sformatf("frame%0d_k%0d", idx, k), {frame_start, sel, led}, e);
      if (k == f.s1k) begin
        data = f.s1v; data_vld = 1'b1;
      end else if (k == f.s2k) begin
        data = f.s2v; data_vld = 1'b1;
      end else begin
        data_vld = 1'b0;
      end
      if (k == f.bk) blink_en = 1'b0;
      @(negedge sys_clk);
    end
    data_vld = 1'b0;
  endtask

  task automatic wait_fs2(input string name);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge sys_clk);
      if (frame_start2) seen = 1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: frame_start2 got 0 required 1 within 30 cycles", name);
    end
  endtask

  always @(negedge sys_clk) begin
    if (mon_en) begin
      n_cmp++;
      if ($countones(~sel) > 1 || $countones(sel2) > 1) begin
        n_bad++;
        $display("FAIL onehot: sel=%b sel2=%b required at most one active each", sel, sel2);
      end
    end
  end

  initial begin
    logic [6:0] e2;

    tbl[0]  = mk(0, 0,  2, 8'hA5, -1, 8'h00, -1, 8'h00, 0, 0);
    tbl[1]  = mk(1, 0,  3, 8'h3C,  8, 8'hC3, -1, 8'hA5, 0, 0);
    tbl[2]  = mk(1, 0,  0, 8'h5A, -1, 8'h00, -1, 8'hC3, 0, 0);
    tbl[3]  = mk(1, 0, -1, 8'h00, -1, 8'h00, -1, 8'h5A, 0, 0);
    tbl[4]  = mk(1, 1, -1, 8'h00, -1, 8'h00, -1, 8'h5A, 0, 0);
    tbl[5]  = mk(1, 1, -1, 8'h00, -1, 8'h00, -1, 8'h5A, 0, 0);
    tbl[6]  = mk(1, 1,  4, 8'h0F, -1, 8'h00, -1, 8'h5A, 1, 1);
    tbl[7]  = mk(1, 1, -1, 8'h00, -1, 8'h00, -1, 8'h0F, 1, 1);
    tbl[8]  = mk(1, 1, -1, 8'h00, -1, 8'h00, -1, 8'h0F, 0, 0);
    tbl[9]  = mk(1, 1,  5, 8'h96, -1, 8'h00, -1, 8'h0F, 0, 0);
    tbl[10] = mk(1, 1, -1, 8'h00, -1, 8'h00,  3, 8'h96, 1, 0);
    tbl[11] = mk(1, 0, -1, 8'h00, -1, 8'h00, -1, 8'h96, 0, 0);

    rst_n = 1'b0; data = '0; data_vld = 1'b0; blink_en = 1'b0;
    data2 = '0; data_vld2 = 1'b0; blink_en2 = 1'b0;
    repeat (3) @(negedge sys_clk);
    cmp("reset_dut",  {frame_start,  sel,  led},  7'b0_11_1111);
    cmp("reset_dut2", {frame_start2, sel2, led2}, 7'b0_00_0000);

    rst_n = 1'b1;
    #1;
    mon_en = 1;
    for (int i = 0; i < 12; i++) check_frame(i, tbl[i]);

    // Reset pulse in the middle of group 0's SHOW.
    repeat (2) @(negedge sys_clk);
    cmp("pre_reset_show", {frame_start, sel, led}, {1'b0, 2'b10, ~4'h9});
    rst_n = 1'b0;
    #1;
    cmp("async_reset", {frame_start, sel, led}, 7'b0_11_1111);
    @(negedge sys_clk);
    rst_n = 1'b1;
    #1;
    check_frame(12, mk(0, 0, -1, 8'h00, -1, 8'h00, -1, 8'h00, 0, 0));
    check_frame(13, mk(1, 0, -1, 8'h00, -1, 8'h00, -1, 8'h00, 0, 0));

    // Active-high, no-gap instance: 9-cycle frames, groups back-to-back.
    wait_fs2("dut2_first_frame");
    @(negedge sys_clk);
    data2 = 8'h5C; data_vld2 = 1'b1;
    @(negedge sys_clk);
    data_vld2 = 1'b0;
    wait_fs2("dut2_second_frame");
    for (int k = 0; k < 9; k++) begin
      if (k == 0)      e2 = {1'b1, 2'b00, 4'h0};
      else if (k <= 4) e2 = {1'b0, 2'b01, 4'h5};
      else             e2 = {1'b0, 2'b10, 4'hC};
      cmp($sformatf("dut2_k%0d", k), {frame_start2, sel2, led2}, e2);
      @(negedge sys_clk);
    end
    cmp("dut2_next_load", {frame_start2, sel2, led2}, 7'b1_00_0000);

    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_scan.md
Name: led_scan

Overview:
- Parametrised time-multiplexed LED driver.
- Splits a GROUPS*GW-bit data word into GROUPS slices of GW bits and shows them one at a time on a shared GW-bit LED bus, with a one-hot group-select bus.
- Adds frame-synchronous data update, inter-group blanking, output polarity selection and frame-based blinking.
- Sits between register/status logic and the board LED/segment pins.

Parameters:
- GROUPS, 2, number of multiplexed groups (>=1).
- GW, 4, LEDs per group (>=1).
- DWELL, 25_000_000, sys_clk cycles each group is shown (>=1).
- BLANK, 0, dead cycles after each group, all outputs inactive (>=0).
- ACTIVE_LOW, 1, 1 = sel and led are driven active-low; 0 = active-high.
- BLINK_FRAMES, 8, frames per blink half-period (>=1).

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- data  in  GROUPS*GW  display word; group 0 = MSB slice.
- data_vld  in  1  one-cycle strobe requesting `data` be displayed.
- blink_en  in  1  enables blinking; level-sensitive.
- sel  out  GROUPS  one-hot group enable (polarity per ACTIVE_LOW).
- led  out  GW  LED drive for the selected group (polarity per ACTIVE_LOW).
- frame_start  out  1  one-cycle pulse in the LOAD cycle.

Behaviour:
- Reset (rst_n low, async):
  - sel and led are inactive: all-ones if ACTIVE_LOW, else all-zeros.
  - frame_start=0.
  - State=LOAD, group index=0, dwell counter=0, shadow=0, pending flag=0, pend_data=0, frame counter=0, blink phase=ON.
- Capture:
  - data_vld=1 copies data into pend_data and sets pending.
  - A later strobe before LOAD overwrites pend_data; the last value wins.
- FSM states: LOAD, SHOW, GAP. All outputs are registered.
- LOAD (1 cycle):
  - If pending, shadow<=pend_data and pending cleared.
  - data_vld in the same cycle as LOAD: that value is taken into pend_data, not shadow, and pending stays set for the next frame.
  - frame_start=1; sel/led inactive; group index<=0.
  - Frame counter and blink phase update here.
  - Next state: SHOW.
- SHOW (exactly DWELL cycles):
  - sel asserts bit g only.
  - led = shadow slice g, where slice g = shadow[(GROUPS-g)*GW-1 -: GW].
  - If blink phase is OFF and blink_en=1, sel/led are inactive for the whole group.
  - Then GAP if BLANK>0; otherwise the next group's SHOW, or LOAD after group GROUPS-1.
- GAP (BLANK cycles):
  - sel/led inactive.
  - Then the next group's SHOW, or LOAD after the last group.
- Outputs follow the state with 1-cycle register latency: the first SHOW cycle of group g drives sel[g] on the clock edge that enters SHOW.
- Frame period = 1 + GROUPS*(DWELL+BLANK) cycles.
- Blink:
  - In LOAD, the frame counter increments.
  - When it reaches BLINK_FRAMES-1 it wraps to 0 and the phase toggles.
  - When blink_en=0, phase is forced ON and the counter held at 0.
  - blink_en rising takes effect at the next LOAD; blink_en falling un-blanks at the next group boundary.
- Counter widths:
  - Dwell counter is $clog2(DWELL+BLANK+1) bits; it compares against DWELL-1 and BLANK-1, with no free-running wrap.
  - Group index is $clog2(GROUPS) bits, minimum 1.
- GROUPS=1: sel is constant-active during SHOW.
- Reset mid-frame: outputs go inactive immediately (async); scanning restarts from LOAD with shadow=0.
- No output ever has more than one sel bit active, including across group transitions.

Decomposition:
- Package led_pkg holds:
  - the state encoding enum (LOAD/SHOW/GAP);
  - the polarity helper function `drive(val, ACTIVE_LOW)`;
  - the default DWELL constant.
- Sub-module led_blink: owns the frame counter and blink phase. Inputs: frame_start, blink_en. Output: blink_off.
- Scan FSM, shadow and pending logic stay in led_scan.

Test Plan (GROUPS=2, GW=4, DWELL=4, BLANK=1, ACTIVE_LOW=1, BLINK_FRAMES=2; frame = 11 cycles):
- Reset then data=8'hA5 with data_vld at cycle 2 -> the following frame shows sel=2'b10/led=4'h5 for 4 cycles, 1 blank cycle (sel=2'b11, led=4'hF), then sel=2'b01/led=4'hA for 4 cycles.
- data_vld with 8'h3C, then 8'hC3, within one frame -> the next frame displays only 8'hC3; the current frame keeps the old shadow throughout.
- data_vld asserted exactly in the LOAD cycle -> the value appears one frame later, not in the frame being started.
- blink_en=1 held -> display pattern is 2 frames on, 2 frames off; during the off frames sel=2'b11, led=4'hF, and frame_start still pulses every 11 cycles.
- rst_n pulsed low mid-SHOW -> sel=2'b11, led=4'hF in the same cycle; after release, LOAD then SHOW with led=4'hF (shadow 0, active-low).
- ACTIVE_LOW=0, BLANK=0 -> sel=2'b01 then 2'b10 back-to-back, led equals the slices uninverted, one-hot checked every cycle.
